datapath_issuer: RTL
====================

Name: datapath_issuer

Overview:
- Sequential front end that owns the operand side of the N-bit arithmetic datapath.
- Accepts operation commands {opcode, A, B} over a valid/ready interface and buffers them in a small FIFO.
- Drives each command onto the datapath's A/B/opcode inputs, waits a settle interval, then captures Y and co.
- Returns each result, tagged with its opcode, over a second valid/ready interface, in order.

Parameters:
- N, 16, operand/result width; must match the attached datapath.
- DEPTH, 4, command FIFO entries; power of two, ≥2.
- SETTLE, 1, cycles operands are held on dp_* before Y/co are sampled; ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept a command (= !full).
- cmd_opcode  in  3  operation code.
- cmd_a  in  N  signed operand A.
- cmd_b  in  N  signed operand B.
- dp_opcode  out  3  to datapath opcode.
- dp_a  out  N  to datapath A.
- dp_b  out  N  to datapath B.
- dp_y  in  N  from datapath Y (combinational).
- dp_co  in  1  from datapath co.
- rsp_valid  out  1  result present.
- rsp_ready  in  1  consumer accepts result.
- rsp_y  out  N  captured Y.
- rsp_co  out  1  captured co.
- rsp_opcode  out  3  opcode that produced the result.
- issue_count  out  16  completed responses, wraps modulo 2^16.

Behaviour:
- Reset (async, rst_n=0): all registered outputs go to 0, i.e. dp_*, rsp_*, rsp_valid, issue_count; FIFO empty; FSM=IDLE. Reset mid-operation discards all queued and in-flight commands.
- cmd_ready=0 during reset.
- Push: occurs on an edge with cmd_valid&&cmd_ready. Pop and push may occur on the same edge; occupancy is then unchanged. Full: cmd_ready=0 and no write. Pointers wrap at DEPTH.
- FSM states: IDLE, DRIVE, RESP.
- IDLE:
  - FIFO non-empty → pop the head into dp_opcode/dp_a/dp_b, load settle counter=SETTLE-1, go DRIVE.
  - A command pushed at edge k is popped at edge k+1 (no bypass).
- DRIVE:
  - dp_* held constant.
  - Counter=0 → at that edge register rsp_y=dp_y, rsp_co=dp_co, rsp_opcode=dp_opcode, set rsp_valid=1, go RESP. Otherwise decrement.
  - Latency with SETTLE=1, empty pipeline: cmd accepted at edge k → rsp_valid high after edge k+2.
- RESP:
  - rsp_* stable while rsp_valid&&!rsp_ready.
  - On handshake edge: issue_count+1; if FIFO non-empty, pop the next command into dp_* and go DRIVE (rsp_valid=0 the following cycle); else rsp_valid=0 and go IDLE.
- dp_* hold their last value outside DRIVE; they change only on a pop edge.
- Results are returned strictly in command order; exactly one response per accepted command.
- No arithmetic is performed locally; Y/co are passed through bit-exact with width N.

Test Plan:
- Single op, N=16, SETTLE=1:
  - Stimulus: push opcode=000, A=100, B=-30; rsp_ready=1.
  - Required: rsp_valid high two cycles after acceptance; rsp_y=70; rsp_co equals the datapath co for the same inputs; rsp_opcode=000; issue_count=1.
- Backpressure/full:
  - Stimulus: hold rsp_ready=0 and push 6 commands.
  - Required: cmd_ready drops after the FIFO holds 4 entries; the first result stays stable on rsp_* for 10 cycles.
  - Then assert rsp_ready; all 5 accepted results drain in order; issue_count=5.
- Back-to-back:
  - Stimulus: 8 commands with A=i, B=2i, opcode=000; rsp_ready=1.
  - Required: rsp_y sequence 0,3,6,…,21; the next DRIVE starts on the handshake edge.
- SETTLE=3:
  - Required: dp_* stable for 3 cycles before capture; latency from acceptance to rsp_valid = 4 edges.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously while in DRIVE with 2 entries queued.
  - Required: rsp_valid, dp_*, and issue_count are 0 immediately; after release no stale response appears.
- Wrap:
  - Stimulus: preload 65535 completions (or force the counter) and complete one more.
  - Required: issue_count=0.
  - Also push/pop on the same edge at occupancy 3: occupancy stays 3.

Source files
------------

// File: rtl/datapath_issuer.sv
// Operand-side front end for the N-bit arithmetic datapath: queues {opcode, A, B}
// commands, holds each on dp_* for SETTLE cycles, then returns the captured Y/co in order.
module datapath_issuer #(
  parameter int N      = 16,
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_opcode,
  input  logic [N-1:0] cmd_a,
  input  logic [N-1:0] cmd_b,
  output logic [2:0]   dp_opcode,
  output logic [N-1:0] dp_a,
  output logic [N-1:0] dp_b,
  input  logic [N-1:0] dp_y,
  input  logic         dp_co,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_y,
  output logic         rsp_co,
  output logic [2:0]   rsp_opcode,
  output logic [15:0]  issue_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE - 1);
  localparam logic [AW:0]   FULL_COUNT  = (AW + 1)'(DEPTH);

  typedef struct packed {
    logic [2:0]   opcode;
    logic [N-1:0] a;
    logic [N-1:0] b;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_e;

  cmd_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  state_e        state_q, state_d;
  logic [CW-1:0] settle_q, settle_d;
  cmd_t          dp_q, dp_d;
  logic [N-1:0]  rsp_y_q, rsp_y_d;
  logic          rsp_co_q, rsp_co_d;
  logic [2:0]    rsp_op_q, rsp_op_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [15:0]   issue_count_q, issue_count_d;
  logic          full, empty, push, pop;

  assign full      = (count_q == FULL_COUNT);
  assign empty     = (count_q == '0);
  assign cmd_ready = rst_n && !full;
  assign push      = cmd_valid && cmd_ready;

  // NOTE: storage has no reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{opcode: cmd_opcode, a: cmd_a, b: cmd_b};
  end

  // NOTE: every signal gets its default first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d       = state_q;
    settle_d      = settle_q;
    dp_d          = dp_q;
    rsp_y_d       = rsp_y_q;
    rsp_co_d      = rsp_co_q;
    rsp_op_d      = rsp_op_q;
    rsp_valid_d   = rsp_valid_q;
    issue_count_d = issue_count_q;
    pop           = 1'b0;

    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          dp_d     = mem_q[rd_ptr_q];
          settle_d = SETTLE_LOAD;
          state_d  = DRIVE;
        end
      end
      DRIVE: begin
        if (settle_q == '0) begin
          rsp_y_d     = dp_y;
          rsp_co_d    = dp_co;
          rsp_op_d    = dp_q.opcode;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          issue_count_d = issue_count_q + 16'd1;
          rsp_valid_d   = 1'b0;
          // Chain straight into the next command so the handshake edge is also the pop edge.
          if (!empty) begin
            pop      = 1'b1;
            dp_d     = mem_q[rd_ptr_q];
            settle_d = SETTLE_LOAD;
            state_d  = DRIVE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      settle_q      <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      dp_q          <= '0;
      rsp_y_q       <= '0;
      rsp_co_q      <= 1'b0;
      rsp_op_q      <= '0;
      rsp_valid_q   <= 1'b0;
      issue_count_q <= '0;
    end else begin
      state_q       <= state_d;
      settle_q      <= settle_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      dp_q          <= dp_d;
      rsp_y_q       <= rsp_y_d;
      rsp_co_q      <= rsp_co_d;
      rsp_op_q      <= rsp_op_d;
      rsp_valid_q   <= rsp_valid_d;
      issue_count_q <= issue_count_d;
    end
  end

  assign dp_opcode   = dp_q.opcode;
  assign dp_a        = dp_q.a;
  assign dp_b        = dp_q.b;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_y       = rsp_y_q;
  assign rsp_co      = rsp_co_q;
  assign rsp_opcode  = rsp_op_q;
  assign issue_count = issue_count_q;

endmodule
